// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C write arbiter: FSM states, command
// field widths and the byte-count clamp applied when a command is latched.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        FINISH,
        ABORT
    } arb_state_e;

    localparam int SLAVE_W      = 8;
    localparam int POINTER_W    = 16;
    localparam int WDATA_W      = 16;
    localparam int BYTE_NUM_W   = 8;

    localparam int MAX_BYTE_NUM  = 4;
    localparam int ABORT_RST_CYC = 2;
    localparam int CNT_W         = 16;

    typedef struct packed {
        logic [SLAVE_W-1:0]    slave;
        logic [POINTER_W-1:0]  pointer;
        logic [WDATA_W-1:0]    wdata;
        logic [BYTE_NUM_W-1:0] byte_num;
    } cmd_t;

    // The engine only handles 1..MAX_BYTE_NUM bytes; anything else becomes a full write.
    function automatic logic [BYTE_NUM_W-1:0] clamp_byte_num(input logic [BYTE_NUM_W-1:0] bn);
        if (bn == '0 || bn > BYTE_NUM_W'(MAX_BYTE_NUM))
            return BYTE_NUM_W'(MAX_BYTE_NUM);
        return bn;
    endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr,
// wrapping modulo N_REQ, returned as a one-hot grant plus a valid flag.
module i2c_rr_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid
);

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!grant_valid && valid[idx]) begin
                grant[idx]  = 1'b1;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_write_arbiter.sv
// Shares one I2C write engine between N_REQ requesters with round-robin grants.
// Define I2C_ARB_TIMEOUT_EN to add launch/busy timeouts that reset the engine.
module i2c_write_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int GO_LOW_MAX = 16,
    parameter int BUSY_MAX   = 65535
) (
    input  logic                  PT_CK,
    input  logic                  RESET,
    input  logic [N_REQ-1:0]      REQ_VALID,
    input  logic [8*N_REQ-1:0]    REQ_SLAVE,
    input  logic [16*N_REQ-1:0]   REQ_POINTER,
    input  logic [16*N_REQ-1:0]   REQ_WDATA,
    input  logic [8*N_REQ-1:0]    REQ_BYTE_NUM,
    output logic [N_REQ-1:0]      REQ_READY,
    output logic [N_REQ-1:0]      DONE,
    output logic                  DONE_ACK,
    output logic                  DONE_TO,
    output logic                  BUSY,
    output logic                  I2C_GO,
    output logic [7:0]            I2C_SLAVE_ADDRESS,
    output logic [15:0]           I2C_POINTER,
    output logic [15:0]           I2C_WDATA,
    output logic [7:0]            I2C_BYTE_NUM,
    output logic                  I2C_RESET_N,
    input  logic                  I2C_END_OK,
    input  logic                  I2C_ACK_OK
);

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_e       state_q, state_d;
    cmd_t             cmd_q, cmd_d, sel_cmd;
    logic [N_REQ-1:0] owner_q, owner_d;
    logic [N_REQ-1:0] ready_q, ready_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [PTR_W-1:0] rr_q, rr_d, rr_next, win_idx;
    logic             done_ack_q, done_ack_d;
    logic             busy_q, busy_d;
    logic             go_q, go_d;
    logic             ack_q, ack_d;
    logic [N_REQ-1:0] grant;
    logic             grant_valid;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int               BUSY_LIM  = (BUSY_MAX > 65535) ? 65535 : BUSY_MAX;
    localparam logic [CNT_W-1:0] GO_LAST   = CNT_W'(GO_LOW_MAX - 1);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_LIM - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(ABORT_RST_CYC - 1);
    localparam logic [CNT_W-1:0] RST_END   = CNT_W'(ABORT_RST_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_n_q, rst_n_d;
    logic             done_to_q, done_to_d;
`endif

    i2c_rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .valid       (REQ_VALID),
        .rr_ptr      (rr_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i])
                win_idx = PTR_W'(i);
        end
    end

    always_comb begin
        sel_cmd.slave    = REQ_SLAVE[SLAVE_W*win_idx +: SLAVE_W];
        sel_cmd.pointer  = REQ_POINTER[POINTER_W*win_idx +: POINTER_W];
        sel_cmd.wdata    = REQ_WDATA[WDATA_W*win_idx +: WDATA_W];
        sel_cmd.byte_num = clamp_byte_num(REQ_BYTE_NUM[BYTE_NUM_W*win_idx +: BYTE_NUM_W]);
        rr_next          = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        ready_d    = '0;
        done_d     = '0;
        done_ack_d = 1'b0;
        busy_d     = busy_q;
        go_d       = go_q;
        ack_d      = ack_q;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        rst_n_d    = rst_n_q;
        done_to_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (grant_valid && I2C_END_OK) begin
                    cmd_d   = sel_cmd;
                    owner_d = grant;
                    ready_d = grant;
                    rr_d    = rr_next;
                    busy_d  = 1'b1;
                    go_d    = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                // GO must be released while the engine is still busy or it relaunches.
                if (!I2C_END_OK) begin
                    go_d    = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = RUN;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (cnt_q == GO_LAST) begin
                    go_d    = 1'b1;
                    rst_n_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ABORT;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            RUN: begin
                // ack_q freezes once END_OK rises, so it keeps the last byte's ACK.
                if (I2C_END_OK) begin
                    state_d = FINISH;
                end else begin
                    ack_d = I2C_ACK_OK;
`ifdef I2C_ARB_TIMEOUT_EN
                    if (cnt_q == BUSY_LAST) begin
                        rst_n_d = 1'b0;
                        cnt_d   = '0;
                        state_d = ABORT;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
`endif
                end
            end
            FINISH: begin
                done_d     = owner_q;
                done_ack_d = ack_q;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            ABORT: begin
                if (cnt_q == RST_END) begin
                    done_d    = owner_q;
                    done_to_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    if (cnt_q == RST_LAST)
                        rst_n_d = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PT_CK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            owner_q    <= '0;
            rr_q       <= '0;
            ready_q    <= '0;
            done_q     <= '0;
            done_ack_q <= 1'b0;
            busy_q     <= 1'b0;
            go_q       <= 1'b1;
            ack_q      <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            rst_n_q    <= 1'b1;
            done_to_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            done_ack_q <= done_ack_d;
            busy_q     <= busy_d;
            go_q       <= go_d;
            ack_q      <= ack_d;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            rst_n_q    <= rst_n_d;
            done_to_q  <= done_to_d;
`endif
        end
    end

    assign REQ_READY         = ready_q;
    assign DONE              = done_q;
    assign DONE_ACK          = done_ack_q;
    assign BUSY              = busy_q;
    assign I2C_GO            = go_q;
    assign I2C_SLAVE_ADDRESS = cmd_q.slave;
    assign I2C_POINTER       = cmd_q.pointer;
    assign I2C_WDATA         = cmd_q.wdata;
    assign I2C_BYTE_NUM      = cmd_q.byte_num;

`ifdef I2C_ARB_TIMEOUT_EN
    assign I2C_RESET_N = rst_n_q;
    assign DONE_TO     = done_to_q;
`else
    logic unused_cfg;
    assign unused_cfg  = ^{GO_LOW_MAX[0], BUSY_MAX[0], ABORT_RST_CYC[0], CNT_W[0]};
    assign I2C_RESET_N = 1'b1;
    assign DONE_TO     = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Directed bench for i2c_write_arbiter with a small behavioural write engine.
module tb_i2c_write_arbiter;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_slave;
    logic [16*N-1:0] req_pointer;
    logic [16*N-1:0] req_wdata;
    logic [8*N-1:0] req_byte_num;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   done;
    logic           done_ack, done_to, busy, i2c_go, i2c_reset_n;
    logic [7:0]     i2c_slave, i2c_byte_num;
    logic [15:0]    i2c_pointer, i2c_wdata;
    logic           eng_end_ok, eng_ack_ok;

    always #5 clk = ~clk;

    i2c_write_arbiter #(
        .N_REQ      (N),
        .GO_LOW_MAX (16),
        .BUSY_MAX   (65535)
    ) dut (
        .PT_CK             (clk),
        .RESET             (rst),
        .REQ_VALID         (req_valid),
        .REQ_SLAVE         (req_slave),
        .REQ_POINTER       (req_pointer),
        .REQ_WDATA         (req_wdata),
        .REQ_BYTE_NUM      (req_byte_num),
        .REQ_READY         (req_ready),
        .DONE              (done),
        .DONE_ACK          (done_ack),
        .DONE_TO           (done_to),
        .BUSY              (busy),
        .I2C_GO            (i2c_go),
        .I2C_SLAVE_ADDRESS (i2c_slave),
        .I2C_POINTER       (i2c_pointer),
        .I2C_WDATA         (i2c_wdata),
        .I2C_BYTE_NUM      (i2c_byte_num),
        .I2C_RESET_N       (i2c_reset_n),
        .I2C_END_OK        (eng_end_ok),
        .I2C_ACK_OK        (eng_ack_ok)
    );

    // Engine model: 3 cycles per byte, ACK of byte b shown at cycle 3b+1,
    // END_OK rises and ACK_OK clears together on the final cycle.
    logic       eng_busy;
    logic       eng_stall;
    logic [3:0] nack_mask;
    int         eng_cnt, eng_total;

    always @(posedge clk or posedge rst) begin
        if (rst || !i2c_reset_n) begin
            eng_end_ok <= 1'b1;
            eng_ack_ok <= 1'b0;
            eng_busy   <= 1'b0;
            eng_cnt    <= 0;
            eng_total  <= 0;
        end else if (!eng_busy) begin
            if (!i2c_go && !eng_stall) begin
                eng_busy   <= 1'b1;
                eng_end_ok <= 1'b0;
                eng_ack_ok <= 1'b0;
                eng_cnt    <= 0;
                eng_total  <= 3 * int'(i2c_byte_num);
            end
        end else begin
            if (eng_cnt == eng_total - 1) begin
                eng_end_ok <= 1'b1;
                eng_ack_ok <= 1'b0;
                eng_busy   <= 1'b0;
            end else begin
                if (eng_cnt % 3 == 1)
                    eng_ack_ok <= ~nack_mask[eng_cnt / 3];
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    logic [7:0]  exp_slave [N];
    logic [15:0] exp_ptr   [N];
    logic [15:0] exp_wdata [N];
    logic [7:0]  exp_bn    [N];

    task automatic set_req(input int i, input logic [7:0] s, input logic [15:0] p,
                           input logic [15:0] w, input logic [7:0] bn);
        req_slave[8*i +: 8]     = s;
        req_pointer[16*i +: 16] = p;
        req_wdata[16*i +: 16]   = w;
        req_byte_num[8*i +: 8]  = bn;
        exp_slave[i] = s;
        exp_ptr[i]   = p;
        exp_wdata[i] = w;
        exp_bn[i]    = (bn == 8'd0 || bn > 8'd4) ? 8'd4 : bn;
    endtask

    int   cyc = 0;
    int   cur_owner = 0;
    int   stab_err = 0;
    int   proto_err = 0;
    int   txn_no = 0;
    logic busy_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Latched fields must match the owner's command for the whole busy window.
    always @(negedge clk) begin
        int own;
        own = cur_owner;
        if (!rst) begin
            if ($countones(req_ready) > 1 || $countones(done) > 1)
                proto_err <= proto_err + 1;
            if (req_ready != '0) begin
                own = oh_idx(req_ready);
                if (busy_prev) proto_err <= proto_err + 1;
            end
            if (busy && (i2c_slave !== exp_slave[own] || i2c_pointer !== exp_ptr[own] ||
                         i2c_wdata !== exp_wdata[own] || i2c_byte_num !== exp_bn[own]))
                stab_err <= stab_err + 1;
            if (done != '0) begin
                txn_no <= txn_no + 1;
                $display("txn %0d: req=%0d ack=%0d to=%0d slave=0x%02h cyc=%0d",
                         txn_no, oh_idx(done), done_ack, done_to, i2c_slave, cyc);
            end
        end
        cur_owner <= own;
        busy_prev <= busy;
    end

    task automatic wait_ready(output int idx, output int at_cyc);
        logic seen;
        seen = 1'b0; idx = -1; at_cyc = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                seen = 1'b1; idx = oh_idx(req_ready); at_cyc = cyc;
                break;
            end
        end
        check_val("ready_seen", seen, 1'b1);
    endtask

    task automatic wait_done(output int idx, output logic ack, output logic to, output int at_cyc);
        logic seen;
        seen = 1'b0; idx = -1; ack = 1'b0; to = 1'b0; at_cyc = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (done != '0) begin
                seen = 1'b1; idx = oh_idx(done); ack = done_ack; to = done_to; at_cyc = cyc;
                break;
            end
        end
        check_val("done_seen", seen, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx, rc, dc, last_dc, n_done, hi_cnt;
        logic ack, to;
        int   order [4] = '{0, 1, 0, 1};

        req_valid = '0; req_slave = '0; req_pointer = '0; req_wdata = '0; req_byte_num = '0;
        eng_stall = 1'b0; nack_mask = 4'b0000;
        for (int i = 0; i < N; i++) begin
            exp_slave[i] = '0; exp_ptr[i] = '0; exp_wdata[i] = '0; exp_bn[i] = '0;
        end
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_go", i2c_go, 1'b1);
        check_val("rst_reset_n", i2c_reset_n, 1'b1);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_ready", req_ready, '0);
        check_val("rst_done", {done, done_ack, done_to}, '0);
        check_val("rst_fields_a", {i2c_slave, i2c_pointer}, '0);
        check_val("rst_fields_b", {i2c_wdata, i2c_byte_num}, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single request, all bytes ACKed
        set_req(0, 8'h52, 16'h0001, 16'hA5C3, 8'd4);
        req_valid[0] = 1'b1;
        wait_ready(idx, rc);
        check_val("t1_grant", idx, 0);
        check_val("t1_slave", i2c_slave, 8'h52);
        check_val("t1_pointer", i2c_pointer, 16'h0001);
        check_val("t1_wdata", i2c_wdata, 16'hA5C3);
        check_val("t1_byte_num", i2c_byte_num, 8'd4);
        check_val("t1_go_low", i2c_go, 1'b0);
        check_val("t1_busy", busy, 1'b1);
        req_valid[0] = 1'b0;
        req_slave[7:0] = 8'hFF; req_wdata[15:0] = 16'h0000; req_byte_num[7:0] = 8'd1;
        @(negedge clk);
        check_val("t1_go_still_low", i2c_go, 1'b0);
        check_val("t1_end_ok_fell", eng_end_ok, 1'b0);
        @(negedge clk);
        check_val("t1_go_released", i2c_go, 1'b1);
        wait_done(idx, ack, to, dc);
        check_val("t1_done_idx", idx, 0);
        check_val("t1_done_ack", ack, 1'b1);
        check_val("t1_done_to", to, 1'b0);
        check_val("t1_busy_at_done", busy, 1'b0);
        check_val("t1_slave_kept", i2c_slave, 8'h52);

        // Contention from a fresh round-robin pointer
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        set_req(0, 8'h10, 16'h0010, 16'h1111, 8'd2);
        set_req(1, 8'h11, 16'h0011, 16'h2222, 8'd1);
        req_valid = 2'b11;
        last_dc = 0;
        for (int t = 0; t < 4; t++) begin
            wait_ready(idx, rc);
            check_val($sformatf("t2_grant%0d", t), idx, order[t]);
            if (t > 0) check_val($sformatf("t2_gap%0d", t), rc - last_dc, 1);
            if (t == 3) req_valid = 2'b00;
            wait_done(idx, ack, to, dc);
            check_val($sformatf("t2_done%0d", t), idx, order[t]);
            check_val($sformatf("t2_ack%0d", t), ack, 1'b1);
            last_dc = dc;
        end

        // Last byte NACKed after ACKed bytes, then the reverse
        set_req(0, 8'h20, 16'h0010, 16'h1234, 8'd3);
        nack_mask = 4'b0100;
        req_valid[0] = 1'b1;
        wait_ready(idx, rc);
        check_val("t3_grant", idx, 0);
        req_valid[0] = 1'b0;
        wait_done(idx, ack, to, dc);
        check_val("t3_nack_last", ack, 1'b0);
        check_val("t3_to", to, 1'b0);
        set_req(1, 8'h21, 16'h0020, 16'h4321, 8'd3);
        nack_mask = 4'b0001;
        req_valid[1] = 1'b1;
        wait_ready(idx, rc);
        check_val("t3b_grant", idx, 1);
        req_valid[1] = 1'b0;
        wait_done(idx, ack, to, dc);
        check_val("t3b_ack_last", ack, 1'b1);
        nack_mask = 4'b0000;

        // Out-of-range byte counts
        set_req(1, 8'h33, 16'h0100, 16'hBEEF, 8'd0);
        req_valid[1] = 1'b1;
        wait_ready(idx, rc);
        check_val("t4_grant", idx, 1);
        check_val("t4_bn_zero", i2c_byte_num, 8'd4);
        req_valid[1] = 1'b0;
        wait_done(idx, ack, to, dc);
        check_val("t4_done", idx, 1);
        set_req(0, 8'h34, 16'h0101, 16'hCAFE, 8'd9);
        req_valid[0] = 1'b1;
        wait_ready(idx, rc);
        check_val("t4_bn_nine", i2c_byte_num, 8'd4);
        req_valid[0] = 1'b0;
        wait_done(idx, ack, to, dc);

        // Asynchronous reset while RUN
        set_req(0, 8'h44, 16'h0200, 16'h5555, 8'd4);
        req_valid[0] = 1'b1;
        wait_ready(idx, rc);
        req_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        check_val("t5_run_busy", busy, 1'b1);
        check_val("t5_run_go", i2c_go, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_val("t5_go", i2c_go, 1'b1);
        check_val("t5_busy", busy, 1'b0);
        check_val("t5_done", done, '0);
        check_val("t5_slave", i2c_slave, 8'h00);
        check_val("t5_engine_idle", eng_end_ok, 1'b1);
        n_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done != '0) n_done++;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done != '0) n_done++;
        end
        check_val("t5_no_done", n_done, 0);
        set_req(0, 8'h50, 16'h0300, 16'h0A0A, 8'd1);
        set_req(1, 8'h51, 16'h0301, 16'h0B0B, 8'd1);
        req_valid = 2'b11;
        wait_ready(idx, rc);
        check_val("t5_rr_reset", idx, 0);
        req_valid[0] = 1'b0;
        wait_done(idx, ack, to, dc);
        check_val("t5_done0", idx, 0);
        wait_ready(idx, rc);
        check_val("t5_grant1", idx, 1);
        req_valid[1] = 1'b0;
        wait_done(idx, ack, to, dc);
        check_val("t5_done1", idx, 1);

`ifdef I2C_ARB_TIMEOUT_EN
        // Engine never starts: launch timeout, engine reset, then normal service
        eng_stall = 1'b1;
        set_req(0, 8'h60, 16'h0400, 16'h7777, 8'd2);
        req_valid[0] = 1'b1;
        wait_ready(idx, rc);
        check_val("t6_grant", idx, 0);
        req_valid[0] = 1'b0;
        hi_cnt = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!i2c_reset_n) break;
            hi_cnt++;
        end
        check_val("t6_go_low_cycles", hi_cnt, 16);
        check_val("t6_go_high", i2c_go, 1'b1);
        @(negedge clk);
        check_val("t6_rstn_low2", i2c_reset_n, 1'b0);
        @(negedge clk);
        check_val("t6_rstn_back", i2c_reset_n, 1'b1);
        check_val("t6_no_done_yet", done, '0);
        @(negedge clk);
        check_val("t6_done", done, 2'b01);
        check_val("t6_done_to", done_to, 1'b1);
        check_val("t6_done_ack", done_ack, 1'b0);
        eng_stall = 1'b0;
        set_req(1, 8'h61, 16'h0401, 16'h8888, 8'd2);
        req_valid[1] = 1'b1;
        wait_ready(idx, rc);
        check_val("t6_next_grant", idx, 1);
        req_valid[1] = 1'b0;
        wait_done(idx, ack, to, dc);
        check_val("t6_next_ack", ack, 1'b1);
        check_val("t6_next_to", to, 1'b0);
`endif

        @(negedge clk);
        check_val("fields_stable", stab_err, 0);
        check_val("protocol", proto_err, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_write_arbiter.md
Name: i2c_write_arbiter

Overview:
- Shares one I2C_WRITE_WDATA engine between N_REQ requesters, e.g. a sensor-config sequencer and a host register port.
- Round-robin arbitration; latches the winner's command; launches the engine through its GO / END_OK protocol.
- Reports per-requester completion with last-byte ACK status. Sits between requester logic and the engine, on the engine's clock.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- GO_LOW_MAX, 16, max cycles I2C_GO is held low waiting for I2C_END_OK to fall.
- BUSY_MAX, 65535, max cycles a transaction may keep I2C_END_OK low (timeout build only).

Ports:
- PT_CK  in  1  clock, shared with the engine.
- RESET  in  1  asynchronous, active-high reset.
- REQ_VALID  in  N_REQ  per-requester command valid; held until REQ_READY.
- REQ_SLAVE  in  8*N_REQ  packed slave addresses, slice i = [8i+7:8i].
- REQ_POINTER  in  16*N_REQ  packed register pointers.
- REQ_WDATA  in  16*N_REQ  packed write data.
- REQ_BYTE_NUM  in  8*N_REQ  packed byte counts (1..4).
- REQ_READY  out  N_REQ  one-cycle accept pulse, one-hot.
- DONE  out  N_REQ  one-cycle completion pulse, one-hot.
- DONE_ACK  out  1  valid with DONE: 1 = last byte ACKed.
- DONE_TO  out  1  valid with DONE: 1 = timeout abort.
- BUSY  out  1  high from accept until DONE.
- I2C_GO  out  1  engine GO. Idles high; a low level launches a transaction.
- I2C_SLAVE_ADDRESS  out  8  latched command field.
- I2C_POINTER  out  16  latched command field.
- I2C_WDATA  out  16  latched command field.
- I2C_BYTE_NUM  out  8  latched command field.
- I2C_RESET_N  out  1  engine reset, active-low.
- I2C_END_OK  in  1  engine idle flag: low while a transaction runs.
- I2C_ACK_OK  in  1  engine per-byte ACK flag.

Behaviour:
- Reset values:
  - I2C_GO=1, I2C_RESET_N=1; all latched fields 0.
  - REQ_READY, DONE, DONE_ACK, DONE_TO and BUSY all 0.
  - Round-robin pointer = requester 0; FSM = IDLE.
- Reset mid-transaction: same values immediately (asynchronous). The engine must be reset by the same source.
- IDLE: if any REQ_VALID and I2C_END_OK=1, select the winner:
  - Winner = first valid index at or after rr_ptr, wrapping modulo N_REQ.
  - Same edge: latch the four fields, pulse REQ_READY[winner], set rr_ptr = winner+1 (wrapping), BUSY=1, go to LAUNCH.
- LAUNCH:
  - Drive I2C_GO=0 and clear the cycle counter.
  - When I2C_END_OK is sampled 0: I2C_GO=1 next cycle, go to RUN.
  - Counter reaching GO_LOW_MAX goes to ABORT.
  - I2C_GO must return high before the engine finishes, otherwise it re-launches.
- RUN:
  - Register I2C_ACK_OK every cycle (ack_q).
  - On a cycle with I2C_END_OK=1, go to FINISH and capture ack_q. The engine clears ACK_OK on that same edge, so the captured value is the last byte's ACK.
- FINISH: pulse DONE[owner] with DONE_ACK=ack_q and DONE_TO=0; BUSY=0; go to IDLE.
  - A new grant is possible on the next cycle, giving 1 idle cycle between transactions.
- ABORT (timeout build only):
  - Hold I2C_RESET_N=0 for 2 cycles, then 1 cycle with I2C_RESET_N=1.
  - Pulse DONE[owner] with DONE_TO=1, DONE_ACK=0; go to IDLE.
- Latched fields never change between REQ_READY and DONE, regardless of REQ_* inputs.
- Simultaneous REQ_VALID deassertion and grant: the grant stands. Requesters must not drop VALID before READY.
- REQ_BYTE_NUM of 0 or >4: forced to 4 at latch time.
- Width: the cycle counter is 16 bits; BUSY_MAX is clamped to 65535.

Optional Feature:
- Macro I2C_ARB_TIMEOUT_EN.
- Defined: the RUN counter compares against BUSY_MAX, and both GO_LOW_MAX and BUSY_MAX expiry go to ABORT.
- Undefined:
  - No counters and no ABORT state; LAUNCH and RUN wait indefinitely.
  - I2C_RESET_N is tied to 1 and DONE_TO is tied to 0.

Decomposition:
- Package i2c_arb_pkg holds:
  - FSM state enum: IDLE, LAUNCH, RUN, FINISH, ABORT.
  - Constants MAX_BYTE_NUM=4 and ABORT_RST_CYC=2.
  - Field-width localparams: 8/16/16/8.
- One sub-module, i2c_rr_arbiter: combinational N_REQ round-robin pick from (valid, rr_ptr) to a one-hot grant plus a valid flag.

Test Plan:
- Single request: req0 with slave 0x52, pointer 0x0001, wdata 0xA5C3, byte_num 4, engine model ACKs all bytes -> REQ_READY[0] 1 cycle, I2C_GO low until END_OK falls, then DONE[0] with DONE_ACK=1 and the fields unchanged throughout.
- Contention: req0 and req1 valid continuously, 4 transactions -> grant order 0,1,0,1, never two grants overlap, BUSY low exactly 1 cycle between them.
- NACK: engine model NACKs the final byte (ACK_OK=0 before END_OK rises) -> DONE_ACK=0; earlier ACKed bytes do not mask it.
- Launch timeout (macro on): END_OK held high -> after 16 cycles I2C_RESET_N low 2 cycles, DONE with DONE_TO=1, next request then serviced normally.
- Async reset asserted mid-RUN -> I2C_GO=1, BUSY=0, no DONE pulse, FSM IDLE; rr_ptr back to 0, so requester 0 wins first after release.
- BYTE_NUM=0 on req1 -> I2C_BYTE_NUM=4 for that transaction.
